// File: rtl/bt_buffer_ctrl_pkg.sv
// Shared definitions for the Bt operand buffer controller: data width, geometry
// defaults and the controller FSM state encoding.
package bt_buffer_ctrl_pkg;

  localparam int BtBuDaWidth = 512;
  localparam int BT_DEPTH    = 16;
  localparam int BT_AW       = 4;
  localparam int BT_RPT_W    = 8;

  typedef enum logic [1:0] {
    BTC_IDLE  = 2'd0,
    BTC_FILL  = 2'd1,
    BTC_READ  = 2'd2,
    BTC_DRAIN = 2'd3
  } btc_state_e;

  function automatic logic btc_busy(input btc_state_e s);
    return (s != BTC_IDLE);
  endfunction

endpackage

// File: rtl/bt_addr_cnt.sv
// Loadable buffer address counter that wraps to zero at a programmable limit
// and flags the wrap in the same cycle it is taken.
module bt_addr_cnt
  import bt_buffer_ctrl_pkg::*;
#(
  parameter int AW = BT_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_en,
  input  logic [AW-1:0] i_limit,
  output logic [AW-1:0] o_addr,
  output logic          o_wrap
);

  logic [AW-1:0] r_addr;
  logic          w_at_limit;

  assign w_at_limit = (r_addr == i_limit);
  assign o_wrap     = i_en && w_at_limit;
  assign o_addr     = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (o_wrap) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + AW'(1);
    end
  end

endmodule

// File: rtl/bt_buffer_ctrl.sv
// Bt operand buffer sequencer: fills the buffer from the selected source, then
// replays the stored words rpt+1 times to the PE-array operand port.
module bt_buffer_ctrl
  import bt_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = BT_DEPTH,
  parameter int AW    = BT_AW,
  parameter int RPT_W = BT_RPT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ks_sel,
  input  logic [AW:0]      fill_len,
  input  logic [RPT_W-1:0] rpt,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             dst_hold,
  output logic [AW-1:0]    a_Bt,
  output logic             we_Bt,
  output logic             kernelsize_op,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             busy,
  output logic             done
);

  btc_state_e       r_state;
  btc_state_e       w_state_next;
  logic             r_ks;
  logic [AW-1:0]    r_limit;
  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] r_pass;
  logic             r_rd_valid;
  logic             r_rd_last;

  logic [AW:0]      w_len;
  logic [AW-1:0]    w_limit;
  logic             w_start;
  logic             w_fill_acc;
  logic             w_rd_issue;
  logic             w_cnt_en;
  logic             w_wrap;
  logic             w_last_pass;
  logic             w_final_rd;
  logic             w_src_ready;
  logic             w_we;
  logic             w_busy;
  logic             w_done;

  // A zero length selects the whole buffer; the counter works on the last address.
  assign w_len   = (fill_len == '0) ? (AW+1)'(DEPTH) : fill_len;
  assign w_limit = AW'(w_len - (AW+1)'(1));

  assign w_start     = (r_state == BTC_IDLE) && start;
  assign w_fill_acc  = (r_state == BTC_FILL) && src_valid;
  assign w_rd_issue  = (r_state == BTC_READ) && !dst_hold;
  assign w_cnt_en    = w_fill_acc || w_rd_issue;
  assign w_last_pass = (r_pass == r_rpt);
  assign w_final_rd  = w_rd_issue && w_wrap && w_last_pass;

  bt_addr_cnt #(
    .AW(AW)
  ) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_en       (w_cnt_en),
    .i_limit    (r_limit),
    .o_addr     (a_Bt),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BTC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_src_ready  = 1'b0;
    w_we         = 1'b0;
    w_done       = 1'b0;
    w_busy       = btc_busy(r_state);
    case (r_state)
      BTC_IDLE: begin
        if (start) begin
          w_state_next = BTC_FILL;
        end
      end
      BTC_FILL: begin
        w_src_ready = 1'b1;
        w_we        = src_valid;
        if (w_wrap) begin
          w_state_next = BTC_READ;
        end
      end
      BTC_READ: begin
        if (w_final_rd) begin
          w_state_next = BTC_DRAIN;
        end
      end
      BTC_DRAIN: begin
        w_done       = 1'b1;
        w_state_next = BTC_IDLE;
      end
      default: begin
        w_state_next = BTC_IDLE;
      end
    endcase
  end

  // Job parameters are captured once at start; the pass counter stops on the final pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ks    <= 1'b0;
      r_limit <= '0;
      r_rpt   <= '0;
      r_pass  <= '0;
    end else if (w_start) begin
      r_ks    <= ks_sel;
      r_limit <= w_limit;
      r_rpt   <= rpt;
      r_pass  <= '0;
    end else if (w_rd_issue && w_wrap && !w_last_pass) begin
      r_pass  <= r_pass + RPT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_final_rd;
    end
  end

  assign src_ready     = w_src_ready;
  assign we_Bt         = w_we;
  assign busy          = w_busy;
  assign done          = w_done;
  assign kernelsize_op = r_ks;
  assign rd_valid      = r_rd_valid;
  assign rd_last       = r_rd_last;

endmodule

// File: tb/tb_bt_buffer_ctrl.sv
// Self-checking bench for bt_buffer_ctrl: a job table, randomized jobs against a
// job-level model with a behavioural buffer, and reset/stall corner sequences.
`timescale 1ns/1ps
module tb_bt_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ks_sel;
  logic [4:0]  fill_len;
  logic [7:0]  rpt;
  logic        src_valid;
  logic        src_ready;
  logic        dst_hold;
  logic [3:0]  a_Bt;
  logic        we_Bt;
  logic        kernelsize_op;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic        done;

  logic [31:0] src_data;
  logic [31:0] mem [0:15];
  logic [31:0] spo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int fl;
    int rp;
    bit ks;
    int vmode;
    int hmode;
    bit poke;
    int expPulses;
    int expLen;
  } jobVec_t;

  jobVec_t vecs [8];

  bt_buffer_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ks_sel        (ks_sel),
    .fill_len      (fill_len),
    .rpt           (rpt),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .dst_hold      (dst_hold),
    .a_Bt          (a_Bt),
    .we_Bt         (we_Bt),
    .kernelsize_op (kernelsize_op),
    .rd_valid      (rd_valid),
    .rd_last       (rd_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Stand-in for the external buffer: synchronous write, one-cycle synchronous read.
  always @(posedge clk) begin
    if (we_Bt) mem[a_Bt] <= src_data;
    spo <= mem[a_Bt];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ks, input int fl, input int rp,
                               input bit v, input bit h, input logic [31:0] d);
    start     = st;
    ks_sel    = ks;
    fill_len  = 5'(fl);
    rpt       = 8'(rp);
    src_valid = v;
    dst_hold  = h;
    src_data  = d;
  endtask

  task automatic checkIdle(input bit ks, input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid, 0);
    checkOutput({tag, "_rd_last"}, rd_last, 0);
    checkOutput({tag, "_src_ready"}, src_ready, 0);
    checkOutput({tag, "_we_Bt"}, we_Bt, 0);
    checkOutput({tag, "_a_Bt"}, a_Bt, 0);
    checkOutput({tag, "_ks"}, kernelsize_op, ks);
  endtask

  // Runs one job; the model tracks only words written, reads issued and the replay order.
  task automatic runJob(input int fl, input int rp, input bit ks, input int vmode, input int hmode,
                        input bit poke, output int pulses, output int jobLen);
    int n, total, wr, iss, got, cyc, firstWr, doneCyc, holdLeft, bound;
    bit prevIss, prevLast, finished, fillPh, rdPh, drainPh, v, h;
    logic [31:0] data [16];
    n     = (fl == 0) ? 16 : fl;
    total = n * (rp + 1);
    bound = 4 * (n + total) + 40;
    for (int i = 0; i < 16; i++) data[i] = $urandom;
    applyStimulus(1'b1, ks, fl, rp, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("start_busy", busy, 0);
    checkOutput("start_src_ready", src_ready, 0);
    @(posedge clk); #1;
    wr = 0; iss = 0; got = 0; firstWr = -1; doneCyc = -1;
    prevIss = 0; prevLast = 0; finished = 0;
    holdLeft = (hmode == 2) ? 3 : 0;
    for (cyc = 0; cyc < bound && !finished; cyc++) begin
      fillPh  = (wr < n);
      rdPh    = !fillPh && (iss < total);
      drainPh = !fillPh && !rdPh;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      h = 1'b0;
      if (hmode == 1) h = ($urandom_range(0, 2) == 0);
      if (hmode == 2 && rdPh && iss == 6 && holdLeft > 0) begin
        h = 1'b1;
        holdLeft--;
      end
      applyStimulus(poke ? 1'($urandom_range(0, 1)) : 1'b0, ks, fl, rp, v, h,
                    fillPh ? data[wr] : $urandom);
      @(negedge clk);
      checkOutput("busy", busy, 1);
      checkOutput("kernelsize_op", kernelsize_op, ks);
      checkOutput("src_ready", src_ready, fillPh);
      checkOutput("we_Bt", we_Bt, fillPh && v);
      checkOutput("a_Bt", a_Bt, fillPh ? wr : (rdPh ? iss % n : 0));
      checkOutput("rd_valid", rd_valid, prevIss);
      checkOutput("rd_last", rd_last, prevLast);
      checkOutput("done", done, drainPh);
      if (rd_valid === 1'b1) begin
        checkOutput("spo_word", spo, data[got % n]);
        got++;
      end
      if (fillPh && v) begin
        if (firstWr < 0) firstWr = cyc;
        wr++;
      end
      prevLast = rdPh && !h && (iss == total - 1);
      prevIss  = rdPh && !h;
      if (prevIss) iss++;
      if (drainPh) begin
        finished = 1;
        doneCyc  = cyc;
      end
      @(posedge clk); #1;
    end
    checkOutput("job_finished", finished, 1);
    applyStimulus(1'b0, ks, fl, rp, 1'b1, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    checkIdle(ks, "post");
    @(posedge clk); #1;
    applyStimulus(1'b0, ks, fl, rp, 1'b0, 1'b0, 32'h0);
    pulses = got;
    jobLen = (finished && firstWr >= 0) ? (doneCyc - firstWr + 1) : -1;
  endtask

  initial begin
    int pulses, jobLen, fl, rp;
    bit ks;

    vecs[0] = '{16, 0,   1'b1, 0, 0, 1'b0, 16,  33};
    vecs[1] = '{5,  2,   1'b0, 0, 0, 1'b0, 15,  21};
    vecs[2] = '{4,  1,   1'b1, 1, 0, 1'b0, 8,   16};
    vecs[3] = '{8,  0,   1'b0, 0, 2, 1'b0, 8,   20};
    vecs[4] = '{0,  0,   1'b1, 0, 0, 1'b1, 16,  33};
    vecs[5] = '{2,  255, 1'b1, 0, 0, 1'b0, 512, 515};
    vecs[6] = '{1,  0,   1'b0, 0, 0, 1'b0, 1,   3};
    vecs[7] = '{7,  3,   1'b1, 2, 1, 1'b1, 28,  0};

    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 3, 1, 1'b1, 1'b0, 32'h0);
    #12;
    checkIdle(1'b0, "reset");
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      runJob(vecs[i].fl, vecs[i].rp, vecs[i].ks, vecs[i].vmode, vecs[i].hmode, vecs[i].poke,
             pulses, jobLen);
      checkOutput($sformatf("vec%0d_pulses", i), pulses, vecs[i].expPulses);
      if (vecs[i].expLen > 0) checkOutput($sformatf("vec%0d_len", i), jobLen, vecs[i].expLen);
    end

    for (int j = 0; j < 6; j++) begin
      fl = $urandom_range(0, 16);
      rp = $urandom_range(0, 3);
      ks = 1'($urandom_range(0, 1));
      runJob(fl, rp, ks, 2, 1, 1'b1, pulses, jobLen);
      checkOutput($sformatf("rand%0d_pulses", j), pulses, ((fl == 0) ? 16 : fl) * (rp + 1));
    end

    // Reset while pass 1 is about to read word 7 of a 10-word job.
    applyStimulus(1'b1, 1'b1, 10, 2, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    checkOutput("midread_a_Bt", a_Bt, 7);
    checkOutput("midread_busy", busy, 1);
    checkOutput("midread_rd_valid", rd_valid, 1);
    checkOutput("midread_ks", kernelsize_op, 1);
    #2;
    rst = 1'b1;
    #1;
    checkIdle(1'b0, "abort");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    runJob(6, 1, 1'b0, 0, 0, 1'b0, pulses, jobLen);
    checkOutput("after_reset_pulses", pulses, 12);
    checkOutput("after_reset_len", jobLen, 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bt_buffer_ctrl.md
# bt_buffer_ctrl

Sequencing controller for the 4-bank Bt operand buffer (16 words × 512 bits, 1-cycle synchronous read). It owns the buffer's address (`a_Bt`), write enable (`we_Bt`) and source select (`kernelsize_op`). It fills the buffer from the selected upstream source with a valid/ready handshake, then replays the stored words to the downstream multiply stage a programmable number of times. It sits between the Bt/input-B feeders and the PE-array operand port, with one instance per Bt buffer.

## Interface
Parameters:
- `DEPTH`, 16: buffer words; must equal 2^`AW`.
- `AW`, 4: address width.
- `RPT_W`, 8: repeat-count width.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a job; sampled only in IDLE.
- `ks_sel`, input, 1: source select for the job (1 = BtInB path, 0 = input-B path); latched at `start`.
- `fill_len`, input, `AW`+1: words to load, 1..16; 0 is treated as 16; latched at `start`.
- `rpt`, input, `RPT_W`: extra replay passes; total passes = `rpt`+1; latched at `start`.
- `src_valid`, input, 1: upstream word present on the selected source.
- `src_ready`, output, 1: controller accepts a word this cycle.
- `dst_hold`, input, 1: downstream stall; freezes read issue.
- `a_Bt`, output, `AW`: buffer address.
- `we_Bt`, output, 1: buffer write enable.
- `kernelsize_op`, output, 1: buffer source mux select.
- `rd_valid`, output, 1: buffer `spo` holds a valid replay word this cycle.
- `rd_last`, output, 1: the `rd_valid` word is the final word of the final pass.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, FILL, READ, DRAIN.
- IDLE:
  - `start` latches `ks_sel`, `fill_len` and `rpt`, clears the address and pass counter, and moves to FILL.
  - `start` is ignored in any other state.
- FILL:
  - `src_ready` = 1.
  - `we_Bt` = `src_valid`; this is combinational from `src_valid` and the state.
  - Each accepted word writes at `a_Bt`, then the address increments.
  - On the write at address `fill_len`-1, the address resets to 0 and the FSM moves to READ.
- READ:
  - Each cycle with `dst_hold` = 0 issues a read at `a_Bt` and advances the address.
  - After address `fill_len`-1, the address wraps to 0 and the pass counter increments.
  - When the issued read is the last word of pass `rpt`, the FSM moves to DRAIN.
  - `dst_hold` = 1 keeps the address and pass counter unchanged and issues no read.
- DRAIN: lasts one cycle while the final read returns. It asserts `done`, then moves to IDLE.
- `kernelsize_op` drives the latched `ks_sel` in all states. It holds its value after the job, so the buffer mux stays stable.
- `we_Bt` is 0 in every state other than FILL.
- Counter widths:
  - The pass counter is `RPT_W` bits. It compares equal to `rpt`, so there is no overflow at `rpt` = 2^`RPT_W`-1.
  - The address counter is `AW` bits. Its wrap is explicit at `fill_len`-1, not a natural overflow, except when `fill_len` = 16.

## Timing
- Reset values: `a_Bt`=0, `we_Bt`=0, `kernelsize_op`=0, `src_ready`=0, `rd_valid`=0, `rd_last`=0, `busy`=0, `done`=0, state IDLE.
- `start` → FILL takes 1 cycle; `src_ready` rises the cycle after `start`.
- FILL has 0 bubbles: with `src_valid` held high, `fill_len` writes take `fill_len` cycles.
- FILL → READ has 0 bubbles: the first read issues on the cycle after the last write.
- Read latency:
  - `rd_valid` is a registered copy of "read issued".
  - It is high exactly 1 cycle after the issue and aligns with `spo`.
  - `rd_last` aligns the same way.
- No-stall job length: `fill_len` + `fill_len`·(`rpt`+1) + 1 cycles from the first write to `done`.
- `done` is coincident with `rd_last`, in the DRAIN cycle.
- `dst_hold` takes effect in the same cycle. A read issued the previous cycle still produces `rd_valid`.
- `src_valid` while not in FILL is ignored, and no write occurs.
- `rst` mid-job aborts immediately to IDLE with all outputs at reset values. Buffer contents are undefined for the next job.

## Structure
- The shared `define.v` package holds `BtBuDaWidth`, the `DEPTH`/`AW` defaults, and the state encodings `BTC_IDLE`/`BTC_FILL`/`BTC_READ`/`BTC_DRAIN`.
- Sub-module `bt_addr_cnt` is a loadable, wrapping address counter with enable, wrap limit and a wrap pulse output.
- FSM, pass counter and output registers live at top level.
- The buffer itself is instantiated outside this block; this block only drives its control pins.

## Test plan
- Full job: `fill_len`=16, `rpt`=0, `ks_sel`=1, `src_valid` held 1.
  - Required: 16 writes at addresses 0..15 with `kernelsize_op`=1.
  - Required: 16 `rd_valid` cycles returning the written words in order; `rd_last`+`done` on cycle 33 after the first write.
- Short and repeated: `fill_len`=5, `rpt`=2.
  - Required: reads at addresses 0..4 ×3, 15 `rd_valid` pulses, and `rd_last` only on the 15th.
  - Required: `a_Bt` never exceeds 4.
- Handshake gaps: `src_valid` toggles 1,0,1,0 during FILL.
  - Required: `we_Bt` only on valid cycles, and the address advances only on those cycles.
- Stall: `dst_hold`=1 for 3 cycles mid-READ.
  - Required: `a_Bt` frozen for 3 cycles.
  - Required: exactly one in-flight `rd_valid`, then a gap, and no word duplicated or skipped.
- Edge cases: `fill_len`=0, which must behave as 16; `start` during READ, which is ignored; `rpt`=255, which must give 256 passes and then `done`.
- Reset mid-READ: assert `rst` at pass 1, word 7.
  - Required: all outputs go to reset values asynchronously, state is IDLE, and a new `start` runs a clean job.
